aes_io_sequencer: RTL and testbench

Bus-side controller between the 32-bit chip I/O bus and the AES128 core. It assembles 128-bit message and key blocks from four 32-bit bus writes each, then launches the core in cipher or decipher mode. It waits for completion, captures the 128-bit result and streams it back as four 32-bit reads. The bidirectional DATA pad sits outside this block in the pad wrapper, driven from DATA_OUT/DATA_OE.

---
 rtl/aes_io_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_aes_io_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_io_sequencer.sv
// ============================================================================
// Module   : aes_io_sequencer
// Purpose  : Bus-side controller for an AES128 core. It assembles 128-bit
//            message and key blocks from four 32-bit bus writes each. It then
//            launches the core in cipher or decipher mode, waits for the core
//            to finish, captures the result and streams it back as four
//            32-bit reads.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: AES_IO_TIMEOUT_EN
//   When defined, a RUN that lasts TIMEOUT_CYCLES cycles without core_done
//   is aborted. The abort sets Err and returns the block to IDLE.
// ----------------------------------------------------------------------------
// Ports:
//   CLK              in   system clock, rising edge
//   RESET            in   asynchronous active-low reset
//   Initiate         in   bus transfer request (one word per cycle)
//   Read_or_Write    in   1 = write buffer, 0 = read result
//   Adress           in   write target: 0 = message, 1 = key
//   SelCypher        in   mode sampled on an accepted Start (1 = cipher)
//   Start            in   launch request (edge-qualified internally)
//   DATA_IN          in   bus write data, first word -> bits [127:96]
//   DATA_OUT         out  registered bus read data
//   DATA_OE          out  registered pad drive enable
//   core_msg         out  assembled message block
//   core_key         out  assembled key block
//   core_sel_cypher  out  latched mode
//   core_start       out  one-cycle launch pulse
//   core_done        in   core completion pulse
//   core_result      in   core output, valid with core_done
//   Busy             out  high while the core is running
//   Result_valid     out  result register holds a result
//   Err              out  sticky protocol error
// ============================================================================
`default_nettype none

module aes_io_sequencer #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Initiate,
  input  logic                Read_or_Write,
  input  logic                Adress,
  input  logic                SelCypher,
  input  logic                Start,
  input  logic [DATA_W-1:0]   DATA_IN,
  output logic [DATA_W-1:0]   DATA_OUT,
  output logic                DATA_OE,
  output logic [4*DATA_W-1:0] core_msg,
  output logic [4*DATA_W-1:0] core_key,
  output logic                core_sel_cypher,
  output logic                core_start,
  input  logic                core_done,
  input  logic [4*DATA_W-1:0] core_result,
  output logic                Busy,
  output logic                Result_valid,
  output logic                Err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Word 0 of each block lives in the top slot [3], which maps to bits
  // [127:96] of the flattened vector.
  logic [3:0][DATA_W-1:0] r_msg;
  logic [3:0][DATA_W-1:0] r_key;
  logic [3:0][DATA_W-1:0] r_result;

  logic [1:0]        r_wp_msg;
  logic [1:0]        r_wp_key;
  logic [2:0]        r_msg_cnt;
  logic [2:0]        r_key_cnt;
  logic [1:0]        r_rd_ptr;
  logic              r_start_prev;
  logic              r_core_start;
  logic              r_sel_cypher;
  logic              r_result_valid;
  logic              r_err;
  logic              r_data_oe;
  logic [DATA_W-1:0] r_data_out;

  logic w_in_run;
  logic w_in_result;
  logic w_wr_req;
  logic w_rd_req;
  logic w_start_req;
  logic w_start_ok;
  logic w_start_rej;
  logic w_done;
  logic w_timeout;

  assign w_in_run    = (r_state == ST_RUN);
  assign w_in_result = (r_state == ST_RESULT);
  assign w_wr_req    = Initiate & Read_or_Write;
  assign w_rd_req    = Initiate & ~Read_or_Write;

  // Start is a rising-edge request; a concurrent bus transfer suppresses it
  // silently (no error).
  assign w_start_req = Start & ~r_start_prev & ~Initiate;
  assign w_start_ok  = w_start_req & ~w_in_run &
                       (r_msg_cnt == 3'd4) & (r_key_cnt == 3'd4);
  assign w_start_rej = w_start_req & ~w_start_ok;
  assign w_done      = w_in_run & core_done;

`ifdef AES_IO_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt;

  // The counter holds the number of completed RUN cycles. The abort fires
  // on the edge that would complete cycle TIMEOUT_CYCLES. core_done has
  // priority over the abort on that same edge.
  assign w_timeout = w_in_run & ~core_done &
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_to_cnt <= '0;
    end else if (!w_in_run) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_RESULT: begin
        if (w_start_ok) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_done) begin
          w_state_nxt = ST_RESULT;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Buffers, pointers and status
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_msg          <= '0;
      r_key          <= '0;
      r_result       <= '0;
      r_wp_msg       <= 2'd0;
      r_wp_key       <= 2'd0;
      r_msg_cnt      <= 3'd0;
      r_key_cnt      <= 3'd0;
      r_rd_ptr       <= 2'd0;
      r_start_prev   <= 1'b0;
      r_core_start   <= 1'b0;
      r_sel_cypher   <= 1'b0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_data_oe      <= 1'b0;
      r_data_out     <= '0;
    end else begin
      r_start_prev <= Start;
      r_core_start <= w_start_ok;
      r_data_oe    <= w_rd_req;

      // Writes are ignored while the core is using the buffers.
      if (w_wr_req && !w_in_run) begin
        if (Adress) begin
          r_key[2'd3 - r_wp_key] <= DATA_IN;
          r_wp_key               <= r_wp_key + 2'd1;
          if (r_key_cnt != 3'd4) begin
            r_key_cnt <= r_key_cnt + 3'd1;
          end
        end else begin
          r_msg[2'd3 - r_wp_msg] <= DATA_IN;
          r_wp_msg               <= r_wp_msg + 2'd1;
          if (r_msg_cnt != 3'd4) begin
            r_msg_cnt <= r_msg_cnt + 3'd1;
          end
        end
      end

      // Reads outside RESULT still drive the pad, but with zero data.
      if (w_rd_req) begin
        if (w_in_result) begin
          r_data_out <= r_result[2'd3 - r_rd_ptr];
          r_rd_ptr   <= r_rd_ptr + 2'd1;
        end else begin
          r_data_out <= '0;
        end
      end

      // A launch consumes the message but keeps the key for reuse.
      // Initiate is low here, so no write can collide with these clears.
      if (w_start_ok) begin
        r_sel_cypher   <= SelCypher;
        r_msg_cnt      <= 3'd0;
        r_wp_msg       <= 2'd0;
        r_wp_key       <= 2'd0;
        r_result_valid <= 1'b0;
      end

      if (w_done) begin
        r_result       <= core_result;
        r_result_valid <= 1'b1;
        r_rd_ptr       <= 2'd0;
      end

      if (w_start_ok) begin
        r_err <= 1'b0;
      end else if ((w_wr_req && w_in_run) || (w_rd_req && !w_in_result) ||
                   w_start_rej || w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign DATA_OUT        = r_data_out;
  assign DATA_OE         = r_data_oe;
  assign core_msg        = r_msg;
  assign core_key        = r_key;
  assign core_sel_cypher = r_sel_cypher;
  assign core_start      = r_core_start;
  assign Busy            = w_in_run;
  assign Result_valid    = r_result_valid;
  assign Err             = r_err;

endmodule

`default_nettype wire

// File: tb/tb_aes_io_sequencer.sv
// ============================================================================
// Module   : tb_aes_io_sequencer
// Purpose  : Self-checking bench for aes_io_sequencer. Directed scenarios are
//            followed by a randomized phase. Every output is checked each
//            cycle against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_io_sequencer;

  localparam int TO = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         Initiate = 1'b0;
  logic         Read_or_Write = 1'b0;
  logic         Adress = 1'b0;
  logic         SelCypher = 1'b0;
  logic         Start = 1'b0;
  logic [31:0]  DATA_IN = '0;
  logic [31:0]  DATA_OUT;
  logic         DATA_OE;
  logic [127:0] core_msg;
  logic [127:0] core_key;
  logic         core_sel_cypher;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;
  logic         Busy;
  logic         Result_valid;
  logic         Err;

  aes_io_sequencer #(.DATA_W(32), .TIMEOUT_CYCLES(TO)) u_dut (
    .CLK(CLK), .RESET(RESET), .Initiate(Initiate),
    .Read_or_Write(Read_or_Write), .Adress(Adress), .SelCypher(SelCypher),
    .Start(Start), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
    .core_msg(core_msg), .core_key(core_key),
    .core_sel_cypher(core_sel_cypher), .core_start(core_start),
    .core_done(core_done), .core_result(core_result), .Busy(Busy),
    .Result_valid(Result_valid), .Err(Err)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // Each block is modelled as a list of words, where word 0 is the most
  // significant word.
  logic [31:0] m_buf[2][4];
  int          m_nwr[2];   // total words written since last consume
  int          m_mode;     // 0 idle, 1 running, 2 result held
  logic [31:0] m_res[4];
  int          m_reads;    // words read since capture
  int          m_run_cycles;
  logic [31:0] m_out;
  logic        m_oe, m_pulse, m_sel, m_rv, m_err, m_start_seen;

  function automatic logic [127:0] join4(input logic [31:0] w[4]);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_nwr[b] = 0;
      for (int i = 0; i < 4; i++) m_buf[b][i] = '0;
    end
    for (int i = 0; i < 4; i++) m_res[i] = '0;
    m_mode = 0; m_reads = 0; m_run_cycles = 0;
    m_out = '0; m_oe = 0; m_pulse = 0; m_sel = 0; m_rv = 0; m_err = 0;
    m_start_seen = 0;
  endtask

  // Applies the rules for one clock edge, using the inputs currently driven.
  task automatic model_edge();
    bit launch_req, launch;
    int b;
    launch_req = Start && !m_start_seen && !Initiate;
    launch     = launch_req && m_mode != 1 && m_nwr[0] >= 4 && m_nwr[1] >= 4;
    m_oe = 0; m_pulse = 0;
    if (Initiate && Read_or_Write) begin
      if (m_mode == 1) m_err = 1;
      else begin
        b = int'(Adress);
        m_buf[b][m_nwr[b] % 4] = DATA_IN;
        m_nwr[b]++;
      end
    end
    if (Initiate && !Read_or_Write) begin
      m_oe = 1;
      if (m_mode == 2) begin
        m_out = m_res[m_reads % 4];
        m_reads++;
      end else begin
        m_out = '0;
        m_err = 1;
      end
    end
    if (launch_req && !launch) m_err = 1;
    if (launch) begin
      m_pulse = 1; m_sel = SelCypher; m_rv = 0; m_err = 0;
      m_nwr[0] = 0;
      // The key stays full; only its write position restarts at word 0.
      m_nwr[1] = 4;
      m_mode = 1; m_run_cycles = 0;
    end else if (m_mode == 1) begin
      m_run_cycles++;
      if (core_done) begin
        for (int i = 0; i < 4; i++) m_res[i] = core_result[127-32*i -: 32];
        m_rv = 1; m_reads = 0; m_mode = 2;
      end
`ifdef AES_IO_TIMEOUT_EN
      else if (m_run_cycles >= TO) begin
        m_mode = 0; m_err = 1;
      end
`endif
    end
    m_start_seen = Start;
  endtask

  task automatic compare_all();
    chk("DATA_OUT", DATA_OUT, m_out);
    chk("DATA_OE", DATA_OE, m_oe);
    chk("core_msg", core_msg, join4(m_buf[0]));
    chk("core_key", core_key, join4(m_buf[1]));
    chk("core_sel_cypher", core_sel_cypher, m_sel);
    chk("core_start", core_start, m_pulse);
    chk("Busy", Busy, m_mode == 1);
    chk("Result_valid", Result_valid, m_rv);
    chk("Err", Err, m_err);
  endtask

  // One clock: drive inputs, take the edge, update the model, check at +1.
  task automatic step(input logic ini, input logic rnw, input logic adr,
                      input logic sel, input logic st, input logic [31:0] din,
                      input logic dn, input logic [127:0] res);
    Initiate = ini; Read_or_Write = rnw; Adress = adr; SelCypher = sel;
    Start = st; DATA_IN = din; core_done = dn; core_result = res;
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle1();
    step(0, 0, 0, 0, 0, '0, 0, '0);
  endtask

  task automatic wr(input logic adr, input logic [31:0] d);
    step(1, 1, adr, 0, 0, d, 0, '0);
  endtask

  // Asynchronous reset pulse, asserted and released between clock edges.
  task automatic pulse_reset();
    #2 RESET = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 RESET = 1'b1;
  endtask

  localparam logic [127:0] RES1 = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [31:0] exp_rd [5];
    model_reset();
    RESET = 1'b0;
    #3;
    compare_all();
    @(posedge CLK); #1;
    RESET = 1'b1;
    idle1();

    // T1: assemble blocks and launch cipher.
    wr(0, 32'h01234567); wr(0, 32'h89abcdef); wr(0, 32'h76543210); wr(0, 32'hfedcba98);
    for (int i = 0; i < 4; i++) wr(1, 32'habcdefab);
    step(0, 0, 0, 1, 1, '0, 0, '0);
    chk("t1_msg", core_msg, 128'h0123456789abcdef76543210fedcba98);
    chk("t1_key", core_key, {4{32'habcdefab}});
    chk("t1_start", core_start, 1'b1);
    chk("t1_sel", core_sel_cypher, 1'b1);
    chk("t1_busy", Busy, 1'b1);
    idle1();
    chk("t1_start_off", core_start, 1'b0);

    // T2: completion and five wrapping reads.
    step(0, 0, 0, 0, 0, '0, 1, RES1);
    chk("t2_rv", Result_valid, 1'b1);
    exp_rd = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, 32'h00112233};
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 0, '0, 0, '0);
      chk($sformatf("t2_rd%0d", i), DATA_OUT, exp_rd[i]);
      chk("t2_oe", DATA_OE, 1'b1);
    end
    idle1();
    chk("t2_oe_off", DATA_OE, 1'b0);
    chk("t2_hold", DATA_OUT, 32'h00112233);
    chk("t2_rv_keep", Result_valid, 1'b1);

    // T3: new message only, decipher, key reused.
    for (int i = 0; i < 4; i++) wr(0, 32'h11110000 + i);
    step(0, 0, 0, 0, 1, '0, 0, '0);
    chk("t3_start", core_start, 1'b1);
    chk("t3_sel", core_sel_cypher, 1'b0);
    chk("t3_err", Err, 1'b0);
    step(0, 0, 0, 0, 0, '0, 1, ~RES1);

    // T4: start with only three message words.
    for (int i = 0; i < 3; i++) wr(0, 32'h22220000 + i);
    step(0, 0, 0, 1, 1, '0, 0, '0);
    chk("t4_nostart", core_start, 1'b0);
    chk("t4_err", Err, 1'b1);
    chk("t4_busy", Busy, 1'b0);
    chk("t4_rv", Result_valid, 1'b1);
    idle1();

    // T5: write during RUN, then reset mid-RUN and a stray core_done.
    wr(0, 32'h22220003);
    step(0, 0, 0, 1, 1, '0, 0, '0);
    chk("t5_launch", Busy, 1'b1);
    step(1, 1, 0, 0, 0, 32'hdeadbeef, 0, '0);
    chk("t5_err", Err, 1'b1);
    chk("t5_msg", core_msg, 128'h22220000222200012222000222220003);
    pulse_reset();
    step(0, 0, 0, 0, 0, '0, 1, RES1);
    chk("t5_busy", Busy, 1'b0);
    chk("t5_rv", Result_valid, 1'b0);
    chk("t5_msg0", core_msg, 128'h0);
    chk("t5_key0", core_key, 128'h0);

`ifdef AES_IO_TIMEOUT_EN
    // T6: core never answers.
    for (int i = 0; i < 4; i++) wr(0, 32'h3);
    for (int i = 0; i < 4; i++) wr(1, 32'h4);
    step(0, 0, 0, 1, 1, '0, 0, '0);
    for (int i = 0; i < TO - 1; i++) idle1();
    chk("t6_busy_still", Busy, 1'b1);
    idle1();
    chk("t6_busy", Busy, 1'b0);
    chk("t6_err", Err, 1'b1);
    chk("t6_rv", Result_valid, 1'b0);
`endif

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      step($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom,
           $urandom_range(0, 7) == 0,
           {$urandom, $urandom, $urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
